cordic_result_collector: RTL and testbench
==========================================

Name: cordic_result_collector

Overview:
- Downstream companion to the 8-stage CORDIC pipeline (input register, 8 stages, output register).
- The pipeline has no valid or stall signalling, so this block accepts issue requests and tracks each one through the fixed pipeline latency.
- Captures each result when it emerges, buffers it in a FIFO and presents it to the consumer on a valid/ready handshake.
- Issue is credit-gated, so no result is ever lost when the consumer stalls.

Parameters:
- LATENCY, 10: cycles from issue (coordinates and op_mode sampled by CORDIC) to result on x_or_phase_out/y_or_size_out.
- DEPTH, 8: result FIFO entries; must be a power of two and >= 2.
- TAG_W, 4: width of the user tag carried alongside each request.

Ports:
- clock  in  1  single clock shared with the CORDIC pipeline.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  requester presents an operation to CORDIC this cycle.
- issue_ready  out  1  a credit is available; the CORDIC inputs are sampled this cycle.
- issue_mode  in  1  copy of op_mode (0 rotate, 1 phase calc).
- issue_tag  in  TAG_W  user tag returned with the result.
- cordic_x  in  16  CORDIC x_or_phase_out (Q7.8 sign-magnitude).
- cordic_y  in  16  CORDIC y_or_size_out.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_x  out  16  x result, or phase in phase mode.
- out_y  out  16  y result, or magnitude in phase mode.
- out_mode  out  1  mode of the head entry.
- out_tag  out  TAG_W  tag of the head entry.
- inflight  out  4  number of requests currently inside the delay line.

Behaviour:
- Issue fires when issue_valid && issue_ready.
- issue_ready = (fifo_count + inflight) < DEPTH, registered-state based and combinational from counters.
  - It does not depend on out_ready in the same cycle: a pop does not free a credit until the next cycle.
- Delay line: LATENCY-deep shift register of {valid, mode, tag}.
  - Stage 0 is loaded with {fire, issue_mode, issue_tag} every cycle.
  - The stage LATENCY-1 output is the "return" strobe.
- On return the block pushes {cordic_x, cordic_y, mode, tag}, sampled that same cycle, into the FIFO.
- inflight counter: +1 on fire, -1 on return, unchanged when both occur in the same cycle.
- FIFO behaviour:
  - Push and pop in the same cycle are both honoured and the count is unchanged.
  - Pop only occurs when out_valid && out_ready.
  - Pointers wrap modulo DEPTH.
  - First-word presentation: out_* is driven directly from the head entry, so latency from return to out_valid is 1 cycle.
- Full FIFO: a push is impossible by construction (credit invariant fifo_count + inflight <= DEPTH).
  - If a push would overflow, the push is dropped and the FIFO contents are retained.
- Empty FIFO: out_valid=0 and out_x/out_y/out_mode/out_tag hold their last values.
  - Consumers must not sample them while out_valid=0.
- Total issue-to-out_valid latency = LATENCY + 1 cycles when the FIFO is empty.
- Reset values:
  - issue_ready=1, out_valid=0, out_x=0, out_y=0, out_mode=0, out_tag=0, inflight=0.
  - Delay line and FIFO pointers cleared.
- Reset mid-operation: all in-flight and buffered results are discarded; results emerging from CORDIC after reset are ignored because the delay line is clear.
- No state machine beyond the counters; ordering is strictly issue order.

Optional Feature:
- Macro CORDIC_COLLECT_ERR_EN.
- When defined:
  - Adds output port err_sticky (1 bit), reset 0.
  - It sets and holds on either of two events: issue_valid while issue_ready=0 (protocol violation: CORDIC has sampled an untracked operation), or an attempted push into a full FIFO.
  - Cleared only by reset.
- When undefined: the port and its logic are absent; both events are silently ignored (the overflowing push is dropped).

Decomposition:
- Package cordic_pkg:
  - Fixed-point width constant FXP_W=16, FXP_FRAC=8.
  - Mode encodings MODE_ROTATE=0, MODE_PHASE=1.
  - CORDIC_LATENCY=10.
  - Result record typedef {x, y, mode, tag}.
- One sub-module: cordic_result_fifo (parameterised DEPTH/width, synchronous push/pop, count output, same reset). The delay line and credit logic stay in the top.

Test Plan:
1. Single rotate issue, tag=3, x=0x0100, y=0x0000, angle=0; model drives cordic_x=0x0100, cordic_y=0x0000 at cycle 10 -> out_valid at cycle 11 with out_x=0x0100, out_y=0x0000, out_tag=3, out_mode=0.
2. Back-to-back 8 issues with out_ready=0 -> issue_ready drops to 0 after the 8th; 9th issue_valid is not accepted; inflight peaks at 8; FIFO fills to 8.
3. Drain case 2 with out_ready=1 -> tags 0..7 emerge in order; issue_ready returns 1 the cycle after the first pop.
4. Continuous issue with out_ready=1 -> steady state one result per cycle, issue_ready never deasserts, inflight=10 only if DEPTH>=11 (run with DEPTH=16).
5. Reset asserted at cycle 5 with 4 operations in flight -> inflight=0, out_valid=0 immediately; no output appears for the 4 old operations.
6. With CORDIC_COLLECT_ERR_EN: force issue_valid=1 while issue_ready=0 -> err_sticky=1 next cycle and stays 1 until reset.

Source files
------------

// File: rtl/cordic_result_collector_pkg.sv
// Shared constants and types for the CORDIC result collector slice.
// Holds the fixed-point format, mode encodings, pipeline latency and the result record.
package cordic_pkg;

  localparam int unsigned FXP_W          = 16;
  localparam int unsigned FXP_FRAC       = 8;
  localparam int unsigned CORDIC_LATENCY = 10;
  localparam int unsigned CORDIC_TAG_W   = 4;

  typedef enum logic {
    MODE_ROTATE = 1'b0,
    MODE_PHASE  = 1'b1
  } cordic_mode_e;

  typedef struct packed {
    logic [FXP_W-1:0]        x;
    logic [FXP_W-1:0]        y;
    cordic_mode_e            mode;
    logic [CORDIC_TAG_W-1:0] tag;
  } cordic_result_t;

  function automatic int unsigned result_width(input int unsigned tag_w);
    return 2 * FXP_W + 1 + tag_w;
  endfunction

endpackage

// File: rtl/cordic_result_collector_if.sv
// Issue and result handshake bundle between requester, CORDIC outputs and consumer.
// The collector uses the slave modport; the requester/consumer side uses master.
interface cordic_result_collector_if
  import cordic_pkg::*;
#(
  parameter int unsigned TAG_W = 4
);

  logic             issue_valid;
  logic             issue_ready;
  logic             issue_mode;
  logic [TAG_W-1:0] issue_tag;
  logic [FXP_W-1:0] cordic_x;
  logic [FXP_W-1:0] cordic_y;

  logic             out_valid;
  logic             out_ready;
  logic [FXP_W-1:0] out_x;
  logic [FXP_W-1:0] out_y;
  logic             out_mode;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  issue_valid, issue_mode, issue_tag, cordic_x, cordic_y, out_ready,
    output issue_ready, out_valid, out_x, out_y, out_mode, out_tag
  );

  modport master (
    output issue_valid, issue_mode, issue_tag, cordic_x, cordic_y, out_ready,
    input  issue_ready, out_valid, out_x, out_y, out_mode, out_tag
  );

endinterface

// File: rtl/cordic_result_collector_fifo.sv
// Result FIFO with first-word presentation; when empty the last popped word is held on o_data.
// DEPTH must be a power of two so the pointers wrap naturally.
module cordic_result_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 37
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? r_last : r_mem[r_rd_ptr];

  // Storage needs no reset: it is only observed through r_last or a valid head.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/cordic_result_collector.sv
// Tracks issues through the fixed CORDIC latency, captures results and buffers them credit-gated.
// Optional CORDIC_COLLECT_ERR_EN adds err_sticky for protocol violations and overflow attempts.
module cordic_result_collector
  import cordic_pkg::*;
#(
  parameter int unsigned LATENCY = CORDIC_LATENCY,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  cordic_result_collector_if.slave  bus,
  output logic [3:0]                inflight
`ifdef CORDIC_COLLECT_ERR_EN
  ,
  output logic                      err_sticky
`endif
);

  localparam int unsigned DW  = result_width(TAG_W);
  localparam int unsigned CW  = $clog2(DEPTH + LATENCY + 1);
  localparam int unsigned FCW = $clog2(DEPTH + 1);

  logic [LATENCY-1:0] r_dl_vld;
  logic [LATENCY-1:0] r_dl_mode;
  logic [TAG_W-1:0]   r_dl_tag [LATENCY];
  logic [CW-1:0]      r_inflight;

  logic               w_fire;
  logic               w_ret;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [FCW-1:0]     w_fifo_count;
  logic [DW-1:0]      w_push_data;
  logic [DW-1:0]      w_head;

  // Credits count both buffered and in-flight results, so a pop frees one only next cycle.
  assign bus.issue_ready = (32'(w_fifo_count) + 32'(r_inflight)) < DEPTH;
  assign w_fire          = bus.issue_valid && bus.issue_ready;
  assign w_ret           = r_dl_vld[LATENCY-1];
  assign w_pop           = bus.out_valid && bus.out_ready;
  assign w_push          = w_ret && (!w_full || w_pop);
  assign w_push_data     = {bus.cordic_x, bus.cordic_y, r_dl_mode[LATENCY-1], r_dl_tag[LATENCY-1]};
  assign inflight        = 4'(r_inflight);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dl_vld  <= '0;
      r_dl_mode <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        r_dl_tag[i] <= '0;
      end
    end else begin
      r_dl_vld[0]  <= w_fire;
      r_dl_mode[0] <= bus.issue_mode;
      r_dl_tag[0]  <= bus.issue_tag;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_dl_vld[i]  <= r_dl_vld[i-1];
        r_dl_mode[i] <= r_dl_mode[i-1];
        r_dl_tag[i]  <= r_dl_tag[i-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_inflight <= '0;
    end else if (w_fire && !w_ret) begin
      r_inflight <= r_inflight + CW'(1);
    end else if (!w_fire && w_ret) begin
      r_inflight <= r_inflight - CW'(1);
    end
  end

  cordic_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_fifo_count)
  );

  assign bus.out_valid = !w_empty;
  assign {bus.out_x, bus.out_y, bus.out_mode, bus.out_tag} = w_head;

`ifdef CORDIC_COLLECT_ERR_EN
  logic r_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((bus.issue_valid && !bus.issue_ready) || (w_ret && w_full && !w_pop)) begin
      r_err <= 1'b1;
    end
  end

  assign err_sticky = r_err;
`endif

endmodule

// File: tb/tb_cordic_result_collector.sv
// Randomized scoreboard bench for cordic_result_collector against a queue-based reference model.
module tb_cordic_result_collector;
  import cordic_pkg::*;

  localparam int unsigned LAT   = CORDIC_LATENCY;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAG_W = CORDIC_TAG_W;
  localparam int          NCYC  = 3000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] inflight;
`ifdef CORDIC_COLLECT_ERR_EN
  logic       err_sticky;
`endif

  cordic_result_collector_if #(.TAG_W(TAG_W)) bus ();

  cordic_result_collector #(
    .LATENCY (LAT),
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .inflight   (inflight)
`ifdef CORDIC_COLLECT_ERR_EN
    ,
    .err_sticky (err_sticky)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int             issue;
    int             avail;
    cordic_result_t r;
  } exp_t;

  exp_t           q[$];
  cordic_result_t last_out;
  logic [15:0]    cx [NCYC + LAT + 4];
  logic [15:0]    cy [NCYC + LAT + 4];
  int             cyc = 0;
  int             checks = 0;
  int             errors = 0;
  logic           model_ready = 1'b1;
  logic           model_err = 1'b0;
  logic           prev_viol = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One cycle of stimulus; an accepted issue is pushed into the model with its future result.
  task automatic drive_cycle(input bit v, input bit m, input logic [3:0] t, input bit rdy, input bit dir);
    exp_t e;
    step();
    if (prev_viol) model_err = 1'b1;
    prev_viol = 1'b0;
    if (dir) begin
      cx[cyc + LAT] = 16'(1 << FXP_FRAC);
      cy[cyc + LAT] = 16'h0000;
    end
    bus.cordic_x    = cx[cyc];
    bus.cordic_y    = cy[cyc];
    bus.issue_valid = v;
    bus.issue_mode  = m;
    bus.issue_tag   = t;
    bus.out_ready   = rdy;
    model_ready     = (q.size() < DEPTH);
    if (v && model_ready) begin
      e.issue  = cyc;
      e.avail  = cyc + LAT + 1;
      e.r.x    = cx[cyc + LAT];
      e.r.y    = cy[cyc + LAT];
      e.r.mode = m ? MODE_PHASE : MODE_ROTATE;
      e.r.tag  = t;
      q.push_back(e);
    end
    if (v && !model_ready) prev_viol = 1'b1;
  endtask

  task automatic do_reset(input int n);
    step();
    reset           = 1'b1;
    q.delete();
    last_out        = '0;
    model_ready     = 1'b1;
    model_err       = 1'b0;
    prev_viol       = 1'b0;
    bus.issue_valid = 1'b0;
    repeat (n) drive_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  always @(negedge clock) begin : monitor
    logic ev;
    int   nin;
    ev = (q.size() > 0) && (q[0].avail <= cyc);
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    nin = 0;
    foreach (q[i]) if (q[i].issue < cyc && cyc <= q[i].issue + int'(LAT)) nin++;
    chk("inflight", 32'(inflight), 32'(nin));
    chk("issue_ready", 32'(bus.issue_ready), 32'(model_ready));
`ifdef CORDIC_COLLECT_ERR_EN
    chk("err_sticky", 32'(err_sticky), 32'(model_err));
`endif
    if (ev) begin
      chk("out_x", 32'(bus.out_x), 32'(q[0].r.x));
      chk("out_y", 32'(bus.out_y), 32'(q[0].r.y));
      chk("out_mode", 32'(bus.out_mode), 32'(q[0].r.mode));
      chk("out_tag", 32'(bus.out_tag), 32'(q[0].r.tag));
      if (bus.out_ready) begin
        last_out = q[0].r;
        void'(q.pop_front());
      end
    end else begin
      chk("hold_x", 32'(bus.out_x), 32'(last_out.x));
      chk("hold_y", 32'(bus.out_y), 32'(last_out.y));
      chk("hold_mode", 32'(bus.out_mode), 32'(last_out.mode));
      chk("hold_tag", 32'(bus.out_tag), 32'(last_out.tag));
    end
  end

  initial begin
    int vp;
    int rp;
    for (int i = 0; i < NCYC + int'(LAT) + 4; i++) begin
      cx[i] = 16'($urandom);
      cy[i] = 16'($urandom);
    end
    last_out        = '0;
    bus.issue_valid = 1'b0;
    bus.issue_mode  = 1'b0;
    bus.issue_tag   = '0;
    bus.cordic_x    = '0;
    bus.cordic_y    = '0;
    bus.out_ready   = 1'b0;
    #1;
    do_reset(3);

    // Single rotate issue with a known CORDIC result.
    drive_cycle(1'b1, 1'b0, 4'd3, 1'b1, 1'b1);
    repeat (14) drive_cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Fill: nine back-to-back issues with the consumer stalled; the ninth must be refused.
    for (int i = 0; i < 9; i++) drive_cycle(1'b1, 1'($urandom), 4'(i), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) drive_cycle(i[1], 1'b0, 4'hf, 1'b0, 1'b0);

    // Drain in order.
    repeat (12) drive_cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Continuous issue with an always-ready consumer.
    repeat (200) drive_cycle(1'b1, 1'($urandom), 4'($urandom), 1'b1, 1'b0);

    // Random traffic with varying issue and consume rates.
    for (int b = 0; b < 15; b++) begin
      vp = int'($urandom_range(100, 10));
      rp = int'($urandom_range(100, 0));
      repeat (100) drive_cycle(($urandom_range(99) < 32'(vp)), 1'($urandom), 4'($urandom),
                               ($urandom_range(99) < 32'(rp)), 1'b0);
    end
    repeat (30) drive_cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Reset with four operations in flight; none of them may surface.
    repeat (4) drive_cycle(1'b1, 1'($urandom), 4'($urandom), 1'b1, 1'b0);
    do_reset(2);
    repeat (20) drive_cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Final burst, then drain completely.
    repeat (40) drive_cycle(1'b1, 1'($urandom), 4'($urandom), 1'($urandom), 1'b0);
    repeat (40) drive_cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
